// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation codes, slice encodings,
// FSM state constants and the opcode-to-slice-control decoder.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] OP_AND  = 2'd0;
   localparam logic [1:0] OP_OR   = 2'd1;
   localparam logic [1:0] OP_SUM  = 2'd2;
   localparam logic [1:0] OP_LESS = 2'd3;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_FIX  = 2'd2;

   typedef struct packed {
      logic       a_invert;
      logic       b_invert;
      logic       cin0;
      logic [1:0] operation;
      logic       arith;
      logic       slt;
   } slice_ctrl_t;

   // Unknown codes select the 'less' leg, which is tied low, so they yield zero.
   function automatic slice_ctrl_t decode_op(input logic [3:0] code);
      slice_ctrl_t c;
      c = '{a_invert: 1'b0, b_invert: 1'b0, cin0: 1'b0, operation: OP_LESS,
            arith: 1'b0, slt: 1'b0};
      case (code)
         ALU_AND: c.operation = OP_AND;
         ALU_OR:  c.operation = OP_OR;
         ALU_ADD: begin c.operation = OP_SUM; c.arith = 1'b1; end
         ALU_SUB: begin
            c.b_invert = 1'b1; c.cin0 = 1'b1; c.operation = OP_SUM; c.arith = 1'b1;
         end
         ALU_SLT: begin
            c.b_invert = 1'b1; c.cin0 = 1'b1; c.operation = OP_LESS;
            c.arith = 1'b1; c.slt = 1'b1;
         end
         ALU_NOR: begin c.a_invert = 1'b1; c.b_invert = 1'b1; c.operation = OP_AND; end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_top_less.sv
// One-bit ALU slice with optional operand inversion, full adder and a 'less'
// input; 'set' exposes the adder sum for SLT evaluation at the MSB.
module alu_top_less
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       less,
   input  logic       a_invert,
   input  logic       b_invert,
   input  logic       cin,
   input  logic [1:0] operation,
   output logic       result,
   output logic       cout,
   output logic       set
);

   logic a_eff;
   logic b_eff;
   logic sum;

   assign a_eff = a ^ a_invert;
   assign b_eff = b ^ b_invert;
   assign sum   = a_eff ^ b_eff ^ cin;
   assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);
   assign set   = sum;

   always_comb begin
      result = 1'b0;
      case (operation)
         OP_AND:  result = a_eff & b_eff;
         OP_OR:   result = a_eff | b_eff;
         OP_SUM:  result = sum;
         default: result = less;
      endcase
   end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: steps one alu_top_less slice LSB-first through all
// WIDTH bits, then a fix-up cycle resolves SLT and loads the output registers.
module serial_alu_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       alu_ctrl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] work;
   logic [CW-1:0]    count;
   logic             carry;
   logic             a_inv_q;
   logic             b_inv_q;
   logic [1:0]       op_q;
   logic             arith_q;
   logic             slt_q;
   logic             set_q;
   logic             cout_q;
   logic             ovf_q;
   slice_ctrl_t      dec;
   logic             s_res;
   logic             s_cout;
   logic             s_set;
   logic [WIDTH-1:0] final_val;

   assign dec  = decode_op(alu_ctrl);
   assign busy = (state != ST_IDLE);

   alu_top_less u_slice (
      .a         (a_sr[0]),
      .b         (b_sr[0]),
      .less      (1'b0),
      .a_invert  (a_inv_q),
      .b_invert  (b_inv_q),
      .cin       (carry),
      .operation (op_q),
      .result    (s_res),
      .cout      (s_cout),
      .set       (s_set)
   );

   // SLT: signed less-than is the MSB sum corrected by overflow.
   always_comb begin
      final_val = work;
      if (slt_q) final_val = {{(WIDTH-1){1'b0}}, set_q ^ ovf_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         work     <= '0;
         count    <= '0;
         carry    <= 1'b0;
         a_inv_q  <= 1'b0;
         b_inv_q  <= 1'b0;
         op_q     <= OP_AND;
         arith_q  <= 1'b0;
         slt_q    <= 1'b0;
         set_q    <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sr    <= src1;
                  b_sr    <= src2;
                  a_inv_q <= dec.a_invert;
                  b_inv_q <= dec.b_invert;
                  op_q    <= dec.operation;
                  arith_q <= dec.arith;
                  slt_q   <= dec.slt;
                  carry   <= dec.cin0;
                  count   <= '0;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               work  <= {s_res, work[WIDTH-1:1]};
               carry <= s_cout;
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               count <= count + CW'(1);
               if (count == LAST) begin
                  set_q  <= s_set;
                  cout_q <= arith_q & s_cout;
                  ovf_q  <= arith_q & (carry ^ s_cout);
                  state  <= ST_FIX;
               end
            end
            ST_FIX: begin
               result   <= final_val;
               zero     <= (final_val == '0);
               cout     <= cout_q;
               overflow <= ovf_q;
               done     <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
